// File: rtl/btb_fetch_unit_if.sv
// Fetch-unit bus: control/update inputs from fetch and resolve, prediction and
// monitoring outputs back to them.
interface btb_fetch_unit_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
);
  logic              pc_en;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              flush;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic [PC_W-1:0]   upd_target;
  logic              upd_taken;
  logic              upd_is_jump;
  logic [PC_W-1:0]   pc;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output pc_en, redirect, redirect_pc, flush,
           upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
    input  pc, pred_taken, pred_target, redirect_cnt
  );

  modport slave (
    input  pc_en, redirect, redirect_pc, flush,
           upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
    output pc, pred_taken, pred_target, redirect_cnt
  );
endinterface

// File: rtl/btb_fetch_unit.sv
// Fetch PC register with a direct-mapped BTB and 2-bit direction counters;
// predicts the next fetch PC in the same cycle and counts redirects.
module btb_fetch_unit #(
  parameter int                ENTRIES  = 16,
  parameter int                PC_W     = 32,
  parameter logic [PC_W-1:0]   PC_INIT  = '0,
  parameter logic [1:0]        CTR_INIT = 2'b01,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  btb_fetch_unit_if.slave    bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0]  valid;
  logic [1:0]          ctr     [ENTRIES];
  logic [TAG_W-1:0]    tag_mem [ENTRIES];
  logic [PC_W-1:0]     tgt_mem [ENTRIES];

  logic [PC_W-1:0]     pc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;
  logic                lk_taken;
  logic [PC_W-1:0]     lk_next;

  logic [IDX_W-1:0]    u_idx;
  logic [TAG_W-1:0]    u_tag;
  logic                u_hit;
  logic                u_active;
  logic                u_alloc;
  logic                u_ctr_we;
  logic                u_tgt_we;
  logic [1:0]          u_ctr;
  logic [1:0]          u_ctr_nxt;

  // Byte-offset bits never participate in lookup or update.
  logic                unused_offset;
  assign unused_offset = ^{bus.pc[1:0], bus.upd_pc[1:0]};

  // Lookup on the current fetch PC, reading pre-edge array state.
  always_comb begin
    lk_idx   = pc_q[IDX_W+1:2];
    lk_tag   = pc_q[PC_W-1:IDX_W+2];
    lk_hit   = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr[lk_idx][1];
    lk_next  = lk_taken ? tgt_mem[lk_idx] : pc_q + PC_W'(4);
  end

  // Update decode from the resolve stage; flush drops the update entirely.
  always_comb begin
    u_idx     = bus.upd_pc[IDX_W+1:2];
    u_tag     = bus.upd_pc[PC_W-1:IDX_W+2];
    u_hit     = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    u_active  = bus.upd_valid && !bus.flush;
    u_alloc   = u_active && !u_hit && (bus.upd_taken || bus.upd_is_jump);
    u_ctr_we  = u_alloc || (u_active && u_hit);
    u_tgt_we  = u_active && (bus.upd_taken || bus.upd_is_jump);
    u_ctr     = ctr[u_idx];
    u_ctr_nxt = u_ctr;
    if (!u_hit) begin
      u_ctr_nxt = bus.upd_is_jump ? 2'b11 : 2'b10;
    end else if (bus.upd_is_jump) begin
      u_ctr_nxt = 2'b11;
    end else if (bus.upd_taken) begin
      u_ctr_nxt = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
    end else begin
      u_ctr_nxt = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
    end
  end

  // Valid bits and direction counters: reset and flush both clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (bus.flush) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else begin
      if (u_alloc)  valid[u_idx] <= 1'b1;
      if (u_ctr_we) ctr[u_idx]   <= u_ctr_nxt;
    end
  end

  // Tag and target storage is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (u_alloc)  tag_mem[u_idx] <= u_tag;
    if (u_tgt_we) tgt_mem[u_idx] <= bus.upd_target;
  end

  // Fetch PC: redirect beats advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_INIT;
    end else if (bus.redirect) begin
      pc_q <= bus.redirect_pc;
    end else if (bus.pc_en) begin
      pc_q <= lk_next;
    end
  end

  // Saturating redirect counter for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pred_taken   = lk_taken;
  assign bus.pred_target  = lk_next;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_btb_fetch_unit.sv
// Directed bench for btb_fetch_unit: fetch sequencing, BTB allocation,
// counter hysteresis, aliasing, priority, flush and asynchronous reset.
module tb_btb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  btb_fetch_unit_if #(.PC_W(32), .CNT_W(16)) bus ();
  btb_fetch_unit_if #(.PC_W(32), .CNT_W(4))  sbus ();

  btb_fetch_unit #(.ENTRIES(16), .PC_W(32), .PC_INIT(32'h0),
                   .CTR_INIT(2'b01), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  btb_fetch_unit #(.ENTRIES(16), .PC_W(32), .PC_INIT(32'h0),
                   .CTR_INIT(2'b01), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t,
                     input logic tk, input logic j);
    bus.upd_valid   = 1'b1;
    bus.upd_pc      = a;
    bus.upd_target  = t;
    bus.upd_taken   = tk;
    bus.upd_is_jump = j;
    tick();
    bus.upd_valid   = 1'b0;
  endtask

  task automatic redir(input logic [31:0] a);
    bus.redirect    = 1'b1;
    bus.redirect_pc = a;
    tick();
    bus.redirect    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.pc_en = 0; bus.redirect = 0; bus.redirect_pc = '0; bus.flush = 0;
    bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_target = '0;
    bus.upd_taken = 0; bus.upd_is_jump = 0;
    sbus.pc_en = 0; sbus.redirect = 0; sbus.redirect_pc = '0; sbus.flush = 0;
    sbus.upd_valid = 0; sbus.upd_pc = '0; sbus.upd_target = '0;
    sbus.upd_taken = 0; sbus.upd_is_jump = 0;
    #12;
    chk("rst_pc", 64'(bus.pc), 64'h0);
    chk("rst_taken", 64'(bus.pred_taken), 64'h0);
    chk("rst_target", 64'(bus.pred_target), 64'h4);
    chk("rst_cnt", 64'(bus.redirect_cnt), 64'h0);
    rst = 1'b0;

    // sequential fetch
    bus.pc_en = 1'b1;
    tick(); chk("seq_pc1", 64'(bus.pc), 64'h4);
    tick(); chk("seq_pc2", 64'(bus.pc), 64'h8);
    tick(); chk("seq_pc3", 64'(bus.pc), 64'hc);
    bus.pc_en = 1'b0;

    // allocation and prediction
    upd(32'h40, 32'h100, 1'b1, 1'b0);
    redir(32'h40);
    chk("alloc_pc", 64'(bus.pc), 64'h40);
    chk("alloc_cnt", 64'(bus.redirect_cnt), 64'h1);
    chk("alloc_taken", 64'(bus.pred_taken), 64'h1);
    chk("alloc_target", 64'(bus.pred_target), 64'h100);
    bus.pc_en = 1'b1; tick(); bus.pc_en = 1'b0;
    chk("follow_pc", 64'(bus.pc), 64'h100);
    chk("follow_miss", 64'(bus.pred_taken), 64'h0);
    chk("follow_target", 64'(bus.pred_target), 64'h104);

    // hysteresis and saturation at 0x40
    redir(32'h40);
    upd(32'h40, 32'h100, 1'b1, 1'b0);
    upd(32'h40, 32'h100, 1'b1, 1'b0);
    chk("ctr11_taken", 64'(bus.pred_taken), 64'h1);
    upd(32'h40, 32'h100, 1'b0, 1'b0);
    chk("ctr10_taken", 64'(bus.pred_taken), 64'h1);
    chk("ctr10_target", 64'(bus.pred_target), 64'h100);
    upd(32'h40, 32'h100, 1'b0, 1'b0);
    chk("ctr01_taken", 64'(bus.pred_taken), 64'h0);
    chk("ctr01_target", 64'(bus.pred_target), 64'h44);
    upd(32'h40, 32'h100, 1'b0, 1'b0);
    upd(32'h40, 32'h100, 1'b0, 1'b0);
    chk("ctr00_taken", 64'(bus.pred_taken), 64'h0);
    // still-valid entry at 00 climbs to 01 (a fresh allocation would predict taken)
    upd(32'h40, 32'h180, 1'b1, 1'b0);
    chk("ctr00_valid", 64'(bus.pred_taken), 64'h0);
    upd(32'h40, 32'h180, 1'b1, 1'b0);
    chk("ctr10_again", 64'(bus.pred_taken), 64'h1);
    chk("ctr10_newtgt", 64'(bus.pred_target), 64'h180);

    // aliasing and jump allocation
    redir(32'h440);
    chk("alias_miss", 64'(bus.pred_taken), 64'h0);
    chk("alias_target", 64'(bus.pred_target), 64'h444);
    upd(32'h440, 32'h200, 1'b0, 1'b1);
    chk("jump_taken", 64'(bus.pred_taken), 64'h1);
    chk("jump_target", 64'(bus.pred_target), 64'h200);
    redir(32'h40);
    chk("evicted_miss", 64'(bus.pred_taken), 64'h0);
    chk("evicted_target", 64'(bus.pred_target), 64'h44);
    chk("cnt_4", 64'(bus.redirect_cnt), 64'h4);

    // redirect beats pc_en
    bus.pc_en = 1'b1;
    redir(32'h80);
    bus.pc_en = 1'b0;
    chk("prio_pc", 64'(bus.pc), 64'h80);
    chk("prio_cnt", 64'(bus.redirect_cnt), 64'h5);

    // same-cycle update and lookup: no bypass
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h80; bus.upd_target = 32'h300;
    bus.upd_taken = 1'b1; bus.upd_is_jump = 1'b0;
    #1;
    chk("nobypass_taken", 64'(bus.pred_taken), 64'h0);
    chk("nobypass_target", 64'(bus.pred_target), 64'h84);
    tick();
    bus.upd_valid = 1'b0;
    chk("nextcyc_taken", 64'(bus.pred_taken), 64'h1);
    chk("nextcyc_target", 64'(bus.pred_target), 64'h300);

    // flush beats a same-cycle update
    bus.flush = 1'b1;
    upd(32'h0c0, 32'h500, 1'b1, 1'b0);
    bus.flush = 1'b0;
    chk("flush_miss", 64'(bus.pred_taken), 64'h0);
    chk("flush_pc", 64'(bus.pc), 64'h80);
    chk("flush_cnt", 64'(bus.redirect_cnt), 64'h5);
    redir(32'h0c0);
    chk("flush_dropped", 64'(bus.pred_taken), 64'h0);
    chk("flush_dropped_tgt", 64'(bus.pred_target), 64'hc4);

    // asynchronous reset in the middle of an update
    upd(32'h0c0, 32'h500, 1'b1, 1'b0);
    chk("pre_rst_taken", 64'(bus.pred_taken), 64'h1);
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h0c0; bus.upd_target = 32'h600;
    bus.upd_taken = 1'b1; bus.upd_is_jump = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", 64'(bus.pc), 64'h0);
    chk("arst_taken", 64'(bus.pred_taken), 64'h0);
    chk("arst_target", 64'(bus.pred_target), 64'h4);
    chk("arst_cnt", 64'(bus.redirect_cnt), 64'h0);
    tick();
    chk("arst_hold_pc", 64'(bus.pc), 64'h0);
    rst = 1'b0;
    bus.upd_valid = 1'b0;
    redir(32'h0c0);
    chk("post_rst_empty", 64'(bus.pred_taken), 64'h0);
    chk("post_rst_target", 64'(bus.pred_target), 64'hc4);
    chk("post_rst_cnt", 64'(bus.redirect_cnt), 64'h1);

    // redirect counter saturation on the narrow-counter instance
    sbus.redirect = 1'b1;
    sbus.redirect_pc = 32'h10;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 64'(sbus.redirect_cnt), 64'he);
    tick();
    chk("sat_15", 64'(sbus.redirect_cnt), 64'hf);
    tick(); tick(); tick();
    chk("sat_hold", 64'(sbus.redirect_cnt), 64'hf);
    sbus.redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_fetch_unit.md
Name: btb_fetch_unit

Overview:
- Parametrised fetch-stage PC unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Replaces the plain PC register and the branch/jump next-PC muxing, so fetch can follow predicted-taken branches and jumps without waiting for resolution.
- Sits between the instruction request path (pc → imemaddr) and the branch-resolution stage, which sends back update and redirect traffic.
- Also keeps a saturating count of redirects for performance monitoring.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- PC_W, 32, PC/target width.
- PC_INIT, 0, PC value after reset.
- CTR_INIT, 2'b01, counter value after reset/flush (weakly not-taken).
- CNT_W, 16, redirect counter width.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- pc_en  in  1  fetch advance (instruction hit); PC moves to predicted next PC.
- redirect  in  1  misprediction correction from the resolve stage.
- redirect_pc  in  PC_W  corrected PC.
- flush  in  1  invalidate all BTB entries.
- upd_valid  in  1  resolved control-transfer update strobe.
- upd_pc  in  PC_W  PC of the resolved branch/jump.
- upd_target  in  PC_W  resolved target.
- upd_taken  in  1  resolved direction.
- upd_is_jump  in  1  unconditional transfer (j/jal/jr).
- pc  out  PC_W  current fetch PC (registered).
- pred_taken  out  1  prediction for current pc (combinational from state).
- pred_target  out  PC_W  predicted next PC: BTB target if pred_taken, else pc+4.
- redirect_cnt  out  CNT_W  saturating redirect count.

Behaviour:
- Indexing: idx = addr[IDX_W+1:2]; tag = addr[PC_W-1:IDX_W+2]. Bits [1:0] are ignored for lookup/update. Entry fields: valid, tag, target (PC_W), ctr (2b).
- Lookup (combinational): hit = valid[idx(pc)] && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? target : pc+4 (mod 2^PC_W, wraps).
- Lookup reads pre-edge state. An update to the same index in the same cycle is visible from the next cycle only; there is no bypass.
- PC register, priority order:
  - RST → PC_INIT.
  - else redirect → redirect_pc (taken as-is).
  - else pc_en → pred_target.
  - else hold.
- Update on upd_valid (flush not asserted), at idx(upd_pc):
  - Hit, upd_is_jump: ctr ← 11; target ← upd_target.
  - Hit, conditional, taken: ctr ← min(ctr+1, 3); target ← upd_target.
  - Hit, conditional, not taken: ctr ← max(ctr−1, 0); target unchanged; entry stays valid.
  - Miss, taken or jump: allocate/overwrite. valid ← 1, tag, target ← upd_target; ctr ← 11 if jump, else 10.
  - Miss, not taken: no change.
- flush: all valid ← 0 and all ctr ← CTR_INIT at the edge. Flush beats a same-cycle upd_valid (the update is dropped). Flush does not affect pc or redirect_cnt.
- redirect_cnt increments by 1 on each cycle redirect=1 and saturates at all-ones (no wrap).
- Reset (asynchronous, any time including mid-update):
  - pc = PC_INIT; all valid = 0; all ctr = CTR_INIT; redirect_cnt = 0.
  - Consequently pred_taken = 0 and pred_target = PC_INIT+4 during and after reset.
  - Target/tag arrays need no reset.
- Latency: prediction is 0-cycle (same cycle as pc). An update is usable 1 cycle after upd_valid.

Test Plan (ENTRIES=16, PC_INIT=0):
- Reset/sequential fetch: RST pulse → pc=0, pred_taken=0, redirect_cnt=0. pc_en=1 for 3 cycles → pc = 4, 8, 12.
- Allocation/prediction: upd_valid, upd_pc=0x40, upd_target=0x100, taken, not jump → ctr=10. Redirect to 0x40 → pred_taken=1, pred_target=0x100. Next pc_en → pc=0x100.
- Hysteresis/saturation at 0x40:
  - Two taken updates → ctr=11.
  - One not-taken → ctr=10, still predicts taken.
  - Second not-taken → ctr=01, pred_taken=0, pred_target=0x44.
  - Two more not-taken → ctr=00, entry still valid.
- Aliasing/jump: with 0x40 allocated, pc=0x440 (same idx 0, different tag) → miss, pred_target=0x444. Jump update at 0x440 → target 0x200 → ctr=11; 0x40 is now evicted and misses.
- Priority/counter:
  - redirect=1 with pc_en=1, redirect_pc=0x80 → pc=0x80, redirect_cnt+1.
  - Preload CNT_W=4 to 15 → stays at 15.
  - Same-cycle update and lookup on pc's index → old prediction this cycle, new prediction next cycle.
- Flush/reset mid-op: flush together with upd_valid → entry not allocated, all lookups miss. Assert RST asynchronously between edges during an update → outputs go to reset values immediately; after release the BTB is empty.
